dvi_video_timing_ctrl: RTL and testbench
========================================

Name: dvi_video_timing_ctrl

Overview:
- Video timing controller sequencing the VGA-to-DVI transmitter. Runs in the pixel clock domain.
- Generates hsync, vsync, data-enable and pixel coordinates, and pulls pixels from an upstream source (framebuffer FIFO) with a ready/valid handshake.
- Drives registered VGA_r/g/b/hs/vs/de straight into the transmitter.
- Handles enable/disable only on frame boundaries, and flags source underflow.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- CW, 12, coordinate counter width

Ports:
- p_clk  in  1  pixel clock
- arstn  in  1  asynchronous active-low reset
- en  in  1  run request; sampled per frame boundary
- pix_data  in  24  {r,g,b} from source
- pix_valid  in  1  source has pixel
- pix_ready  out  1  pixel consumed this cycle when pix_valid=1
- underflow_clr  in  1  clears underflow flag
- underflow  out  1  sticky: active pixel needed but pix_valid=0
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)
- busy  out  1  state is RUN or STOP_PEND
- h_cnt  out  CW  current horizontal counter (pre-register)
- v_cnt  out  CW  current vertical counter (pre-register)
- VGA_r, VGA_g, VGA_b  out  8 each  pixel colour to transmitter
- VGA_hs, VGA_vs, VGA_de  out  1 each  sync/enable to transmitter

Behaviour:
- Constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active, FP, sync, BP. Frame order: same, vertically.
- States:
  - IDLE: counters held 0; pix_ready=0; outputs in blank state.
  - RUN: counters advance.
  - STOP_PEND: counters advance; en dropped mid-frame.
- Transitions:
  - IDLE and en=1 -> RUN next cycle, counters at (0,0).
  - RUN and en=0 -> STOP_PEND.
  - STOP_PEND and en=1 -> RUN; the frame continues uninterrupted.
  - RUN or STOP_PEND at frame end (h=H_TOTAL-1, v=V_TOTAL-1): if en=0 -> IDLE, else wrap to (0,0) and stay in RUN.
- Counters:
  - h_cnt increments each cycle and wraps at H_TOTAL-1 to 0.
  - v_cnt increments on h wrap and wraps at V_TOTAL-1 to 0.
  - Unsigned, no overflow beyond TOTAL-1.
- Active region: act = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE)&&state!=IDLE.
- pix_ready = act, combinational. A transfer occurs when pix_ready&&pix_valid.
- Sync decode:
  - hs_on = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_on uses the same window on v_cnt, independent of h_cnt (edges align with h_cnt=0).
- Output register (1-cycle latency from counters; all VGA_* and frame_start mutually aligned):
  - VGA_de <= act.
  - VGA_hs <= hs_on ? HS_POL : ~HS_POL. VGA_vs likewise with VS_POL.
  - VGA_rgb <= act&&pix_valid ? pix_data : 0. Underflow pixel is black and the line timing is never stalled.
  - frame_start <= (state!=IDLE)&&h_cnt==0&&v_cnt==0.
- underflow:
  - Set when act&&!pix_valid.
  - Cleared by underflow_clr; set wins if both occur on the same cycle.
  - Retained across IDLE.
- Reset (arstn=0, async assert, deassert synchronised externally):
  - state=IDLE, counters 0, pix_ready=0, underflow=0, frame_start=0, busy=0.
  - VGA_de=0, rgb=0, VGA_hs=~HS_POL, VGA_vs=~VS_POL.
  - Reset mid-frame aborts immediately to these values.
- IDLE outputs equal the reset values, except underflow, which holds its value.

Test Plan:
- Reset: with arstn=0, check VGA_hs=1, VGA_vs=1, de=0, rgb=0, pix_ready=0. Assert arstn mid-frame -> same values within the same cycle.
- Small timing (H 8/2/2/2, V 4/1/1/1, pix_valid=1, en=1):
  - frame_start every 98 cycles, first pulse 2 cycles after en rise.
  - VGA_de high for 8 cycles of each of the first 4 lines.
  - 32 transfers per frame.
- Sync positions (small timing): VGA_hs low for output h=10..11; VGA_vs low for all 14 cycles of output line 5. Repeat with HS_POL=1 -> hs high only in that window.
- Underflow: drop pix_valid for 3 active cycles -> VGA_rgb=0 with de=1 for those 3 cycles, underflow=1 and sticky. Pulse underflow_clr on a cycle with a new underflow -> remains 1.
- Stop/restart:
  - en=0 at mid-frame -> frame completes, then IDLE; busy falls one cycle after the frame-end cycle.
  - en toggled 0->1 within a frame -> no gap, next frame_start 98 cycles after the previous one.
- Pixel order: a source supplying an incrementing pix_data -> the VGA_rgb sequence is contiguous across lines and frames, with no drops or duplicates.

Source files
------------

// File: rtl/dvi_video_timing_ctrl.sv
// rtl/dvi_video_timing_ctrl.sv - video timing generator pulling pixels from a ready/valid source for a DVI transmitter
module dvi_video_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12
) (
    input  logic          p_clk,
    input  logic          arstn,
    input  logic          en,
    input  logic [23:0]   pix_data,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic          underflow_clr,
    output logic          underflow,
    output logic          frame_start,
    output logic          busy,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic [7:0]    VGA_r,
    output logic [7:0]    VGA_g,
    output logic [7:0]    VGA_b,
    output logic          VGA_hs,
    output logic          VGA_vs,
    output logic          VGA_de
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SS_C   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE_C   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SS_C   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE_C   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} state_t;
    state_t state;

    logic act, hs_on, vs_on, h_end, v_end;

    assign h_end     = (h_cnt == H_LAST_C);
    assign v_end     = (v_cnt == V_LAST_C);
    assign act       = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C) && (state != IDLE);
    assign hs_on     = (h_cnt >= H_SS_C) && (h_cnt < H_SE_C);
    assign vs_on     = (v_cnt >= V_SS_C) && (v_cnt < V_SE_C);
    assign pix_ready = act;
    assign busy      = (state != IDLE);

    // en only decides whether the next frame starts; a running frame always completes
    always_ff @(posedge p_clk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
            if (en) state <= RUN;
        end else begin
            if (h_end) begin
                h_cnt <= '0;
                v_cnt <= v_end ? '0 : v_cnt + CW'(1);
            end else begin
                h_cnt <= h_cnt + CW'(1);
            end
            if (h_end && v_end) state <= en ? RUN : IDLE;
            else                state <= en ? RUN : STOP_PEND;
        end
    end

    // Output stage: one cycle behind the counters; a starved pixel goes out black
    always_ff @(posedge p_clk or negedge arstn) begin
        if (!arstn) begin
            VGA_de                <= 1'b0;
            VGA_hs                <= ~HS_POL;
            VGA_vs                <= ~VS_POL;
            {VGA_r, VGA_g, VGA_b} <= 24'd0;
            frame_start           <= 1'b0;
            underflow             <= 1'b0;
        end else begin
            VGA_de                <= act;
            VGA_hs                <= hs_on ? HS_POL : ~HS_POL;
            VGA_vs                <= vs_on ? VS_POL : ~VS_POL;
            {VGA_r, VGA_g, VGA_b} <= (act && pix_valid) ? pix_data : 24'd0;
            frame_start           <= (state != IDLE) && (h_cnt == '0) && (v_cnt == '0);
            if (act && !pix_valid) underflow <= 1'b1;
            else if (underflow_clr) underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dvi_video_timing_ctrl.sv
// tb/tb_dvi_video_timing_ctrl.sv - self-checking bench for dvi_video_timing_ctrl on a small 14x7 timing
module tb_dvi_video_timing_ctrl;
    localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;

    logic        p_clk = 1'b0;
    logic        arstn = 1'b1;
    logic        en = 1'b0;
    logic        pix_valid = 1'b0;
    logic        underflow_clr = 1'b0;
    logic [23:0] pix_data = 24'h0;

    logic        pix_ready, underflow, frame_start, busy, VGA_hs, VGA_vs, VGA_de;
    logic [11:0] h_cnt, v_cnt;
    logic [7:0]  VGA_r, VGA_g, VGA_b;
    logic        d1_pix_ready, d1_underflow, d1_frame_start, d1_busy, d1_hs, d1_vs, d1_de;
    logic [11:0] d1_h_cnt, d1_v_cnt;
    logic [7:0]  d1_r, d1_g, d1_b;

    dvi_video_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(12)) dut (
        .p_clk(p_clk), .arstn(arstn), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .underflow_clr(underflow_clr), .underflow(underflow),
        .frame_start(frame_start), .busy(busy), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .VGA_r(VGA_r), .VGA_g(VGA_g), .VGA_b(VGA_b),
        .VGA_hs(VGA_hs), .VGA_vs(VGA_vs), .VGA_de(VGA_de));

    dvi_video_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b0), .CW(12)) dut_hs1 (
        .p_clk(p_clk), .arstn(arstn), .en(en), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(d1_pix_ready), .underflow_clr(underflow_clr), .underflow(d1_underflow),
        .frame_start(d1_frame_start), .busy(d1_busy), .h_cnt(d1_h_cnt), .v_cnt(d1_v_cnt),
        .VGA_r(d1_r), .VGA_g(d1_g), .VGA_b(d1_b),
        .VGA_hs(d1_hs), .VGA_vs(d1_vs), .VGA_de(d1_de));

    always #5 p_clk = ~p_clk;

    typedef struct {
        logic        de, hs0, hs1, vs, fs, uf;
        logic [23:0] rgb;
    } exp_t;

    typedef struct {
        int   n;
        logic de, hs0, hs1, vs, fs;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];
    exp_t sb [$];
    logic [4:0] trace [0:255];

    int   checks = 0, errors = 0;
    logic running = 1'b0, uf_m = 1'b0, fs_seen = 1'b0, busy_s = 1'b0;
    int   pos = 0, cyc = 0, last_fs = 0, fs_gap = 0, xfer_cnt = 0, rec_n = -1000, n_busy = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge, push next expectation, advance the reference position at posedge
    task automatic cycle();
        exp_t e;
        int   h, v;
        logic act, hon, von;
        @(negedge p_clk);
        cyc++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("VGA_de", VGA_de, e.de);
            chk("VGA_hs", VGA_hs, e.hs0);
            chk("VGA_hs_pol1", d1_hs, e.hs1);
            chk("VGA_vs", VGA_vs, e.vs);
            chk("frame_start", frame_start, e.fs);
            chk("underflow", underflow, e.uf);
            chk("VGA_rgb", {VGA_r, VGA_g, VGA_b}, e.rgb);
        end
        if (rec_n >= 0 && rec_n < 256) trace[rec_n] = {VGA_de, VGA_hs, d1_hs, VGA_vs, frame_start};
        rec_n++;
        if (frame_start) begin
            fs_gap  = cyc - last_fs;
            last_fs = cyc;
            fs_seen = 1'b1;
        end
        busy_s = busy;
        h   = running ? pos % HT : 0;
        v   = running ? pos / HT : 0;
        act = running && (h < HA) && (v < VA);
        hon = (h >= HA + HF) && (h < HA + HF + HSW);
        von = (v >= VA + VF) && (v < VA + VF + VSW);
        chk("pix_ready", pix_ready, act);
        chk("busy", busy, running);
        chk("h_cnt", h_cnt, h);
        chk("v_cnt", v_cnt, v);
        if (pix_ready && pix_valid) xfer_cnt++;
        e.de  = act;
        e.hs0 = ~hon;
        e.hs1 = hon;
        e.vs  = ~von;
        e.fs  = running && (pos == 0);
        e.rgb = (act && pix_valid) ? pix_data : 24'd0;
        if (act && !pix_valid) uf_m = 1'b1;
        else if (underflow_clr) uf_m = 1'b0;
        e.uf = uf_m;
        sb.push_back(e);
        @(posedge p_clk);
        if (!running) begin
            if (en) begin running = 1'b1; pos = 0; end
        end else if (pos == FT - 1) begin
            running = en;
            pos     = 0;
        end else begin
            pos++;
        end
        #1;
        if (act && pix_valid) pix_data = pix_data + 24'd1;
    endtask

    task automatic wait_pos(input int p, input string name);
        for (int k = 0; k < 400; k++) begin
            if (running && pos == p) break;
            cycle();
        end
        checks++;
        if (!(running && pos == p)) begin
            errors++;
            $display("FAIL %s: timeout, position %0d not reached (at %0d)", name, p, pos);
        end
    endtask

    task automatic wait_fs(input string name);
        fs_seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (fs_seen) break;
            cycle();
        end
        checks++;
        if (!fs_seen) begin
            errors++;
            $display("FAIL %s: timeout, frame_start got 0 expected 1", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0,  1, 1, 0, 1, 1};
        tbl[1]  = '{1,  1, 1, 0, 1, 0};
        tbl[2]  = '{7,  1, 1, 0, 1, 0};
        tbl[3]  = '{8,  0, 1, 0, 1, 0};
        tbl[4]  = '{9,  0, 1, 0, 1, 0};
        tbl[5]  = '{10, 0, 0, 1, 1, 0};
        tbl[6]  = '{11, 0, 0, 1, 1, 0};
        tbl[7]  = '{12, 0, 1, 0, 1, 0};
        tbl[8]  = '{14, 1, 1, 0, 1, 0};
        tbl[9]  = '{49, 1, 1, 0, 1, 0};
        tbl[10] = '{55, 0, 1, 0, 1, 0};
        tbl[11] = '{56, 0, 1, 0, 1, 0};
        tbl[12] = '{70, 0, 1, 0, 0, 0};
        tbl[13] = '{80, 0, 0, 1, 0, 0};
        tbl[14] = '{83, 0, 1, 0, 0, 0};
        tbl[15] = '{84, 0, 1, 0, 1, 0};
        tbl[16] = '{97, 0, 1, 0, 1, 0};
        tbl[17] = '{98, 1, 1, 0, 1, 1};

        pix_data = 24'h000100;
        #1 arstn = 1'b0;
        #2;
        chk("rst_hs", VGA_hs, 1);
        chk("rst_hs_pol1", d1_hs, 0);
        chk("rst_vs", VGA_vs, 1);
        chk("rst_de", VGA_de, 0);
        chk("rst_rgb", {VGA_r, VGA_g, VGA_b}, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_busy", busy, 0);
        repeat (2) cycle();
        arstn = 1'b1;
        repeat (2) cycle();

        // Two full frames from en rise, trace recorded by output position
        pix_valid = 1'b1;
        en        = 1'b1;
        rec_n     = -2;
        xfer_cnt  = 0;
        repeat (197) cycle();
        chk("xfers_2frames", xfer_cnt, 64);
        for (int i = 0; i < NV; i++) begin
            logic [4:0] t;
            t = trace[tbl[i].n];
            chk($sformatf("tbl_de@%0d", tbl[i].n),  t[4], tbl[i].de);
            chk($sformatf("tbl_hs@%0d", tbl[i].n),  t[3], tbl[i].hs0);
            chk($sformatf("tbl_hs1@%0d", tbl[i].n), t[2], tbl[i].hs1);
            chk($sformatf("tbl_vs@%0d", tbl[i].n),  t[1], tbl[i].vs);
            chk($sformatf("tbl_fs@%0d", tbl[i].n),  t[0], tbl[i].fs);
        end

        // Underflow: three starved active pixels, then clear colliding with a new underflow
        wait_pos(HT + 2, "wait_uf");
        pix_valid = 1'b0;
        repeat (3) cycle();
        pix_valid = 1'b1;
        repeat (20) cycle();
        chk("uf_sticky", underflow, 1);
        wait_pos(3 * HT + 5, "wait_uf_clr");
        pix_valid     = 1'b0;
        underflow_clr = 1'b1;
        cycle();
        pix_valid     = 1'b0;
        underflow_clr = 1'b0;
        pix_valid     = 1'b1;
        chk("uf_clr_collision", underflow, 1);

        // Stop mid-frame: frame runs to completion, then IDLE
        wait_pos(40, "wait_stop");
        en     = 1'b0;
        n_busy = 0;
        repeat (80) begin
            cycle();
            if (busy_s) n_busy++;
        end
        chk("stop_busy_cycles", n_busy, FT - 40);
        chk("uf_held_idle", underflow, 1);
        underflow_clr = 1'b1;
        cycle();
        underflow_clr = 1'b0;
        chk("uf_cleared", underflow, 0);

        // Restart, then a short en dropout inside a frame must not disturb the cadence
        en = 1'b1;
        wait_fs("fs_restart");
        wait_pos(30, "wait_toggle");
        en = 1'b0;
        repeat (5) cycle();
        en = 1'b1;
        wait_fs("fs_toggle");
        chk("toggle_gap", fs_gap, FT);

        // Asynchronous reset in the middle of an active line
        wait_pos(HT + 5, "wait_rst");
        pix_valid = 1'b0;
        cycle();
        pix_valid = 1'b1;
        #2 arstn = 1'b0;
        #1;
        chk("mrst_hs", VGA_hs, 1);
        chk("mrst_hs_pol1", d1_hs, 0);
        chk("mrst_vs", VGA_vs, 1);
        chk("mrst_de", VGA_de, 0);
        chk("mrst_rgb", {VGA_r, VGA_g, VGA_b}, 0);
        chk("mrst_pix_ready", pix_ready, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_frame_start", frame_start, 0);
        chk("mrst_underflow", underflow, 0);
        chk("mrst_h_cnt", h_cnt, 0);
        running = 1'b0;
        pos     = 0;
        uf_m    = 1'b0;
        sb.delete();
        en = 1'b0;
        cycle();
        arstn = 1'b1;
        cycle();
        en = 1'b1;
        repeat (120) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
